// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer: state encoding,
// opcode classes and instruction field positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [2:0] OP_MEM  = 3'd5;
  localparam logic [2:0] OP_NOP  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 13;
  localparam int FLAG_BIT = 0;

  function automatic logic [2:0] op_of(input logic [15:0] insn);
    return insn[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait counter shared by the instruction and data memory handshakes;
// flags a timeout when a request has gone TIMEOUT cycles without an ack.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic busy,
  input  logic ack,
  output logic timeout
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (start || !busy || ack) cnt <= '0;
    else                            cnt <= cnt + 8'd1;
  end

  // cnt holds the number of earlier unacked cycles, so this is the TIMEOUT-th one
  assign timeout = busy && !ack && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb sequencing with
// memory handshakes, instruction register, retire counter and timeout fault.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int TIMEOUT  = 15,
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_rdata,
  output logic [15:0]         ir,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  output logic                alu_en,
  output logic                reg_we,
  output logic [PC_W-1:0]     pc,
  output logic [RETIRE_W-1:0] retired,
  output logic                halted,
  output logic                fault
);

  state_t     state, state_nx;
  logic [2:0] op;
  logic       retire;
  logic       wait_busy, wait_ack, wait_start, timeout;

  assign op = op_of(ir);

  assign wait_busy  = (state == S_FETCH) || (state == S_MEM);
  assign wait_ack   = (state == S_FETCH) ? imem_ack :
                      (state == S_MEM)   ? dmem_ack : 1'b0;
  assign wait_start = ((state_nx == S_FETCH) || (state_nx == S_MEM)) && (state_nx != state);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (wait_start),
    .busy    (wait_busy),
    .ack     (wait_ack),
    .timeout (timeout)
  );

  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    case (state)
      S_IDLE:   if (run) state_nx = S_FETCH;
      S_FETCH: begin
        if (imem_ack)     state_nx = S_DECODE;
        else if (timeout) state_nx = S_FAULT;
      end
      S_DECODE: begin
        if (op == OP_HALT) state_nx = S_HALT;
        else if (op == OP_NOP) begin
          retire   = 1'b1;
          state_nx = run ? S_FETCH : S_IDLE;
        end
        else state_nx = S_EXEC;
      end
      S_EXEC:   state_nx = (op == OP_MEM) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) begin
          if (ir[FLAG_BIT]) begin
            retire   = 1'b1;
            state_nx = run ? S_FETCH : S_IDLE;
          end
          else state_nx = S_WB;
        end
        else if (timeout) state_nx = S_FAULT;
      end
      S_WB: begin
        retire   = 1'b1;
        state_nx = run ? S_FETCH : S_IDLE;
      end
      default:  state_nx = state;  // HALT and FAULT only leave through reset
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ir      <= '0;
      pc      <= '0;
      retired <= '0;
    end
    else begin
      state <= state_nx;
      if (state == S_FETCH && imem_ack) begin
        ir <= imem_rdata;
        pc <= pc + PC_W'(1);
      end
      if (retire && (retired != '1)) retired <= retired + RETIRE_W'(1);
    end
  end

  // Moore outputs straight from the state register, so reset clears them at once
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign dmem_req  = (state == S_MEM);
  assign dmem_we   = (state == S_MEM) && ir[FLAG_BIT];
  assign alu_en    = (state == S_EXEC);
  assign reg_we    = (state == S_WB);
  assign halted    = (state == S_HALT);
  assign fault     = (state == S_FAULT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: random programs through memory responders,
// expected events from an instruction-level timing model, plus directed corners.
module tb_cpu_sequencer;

  localparam int PC_W   = 8;
  localparam int TMO    = 15;
  localparam int RW     = 4;
  localparam int N_RAND = 300;
  localparam int EV_F = 0, EV_A = 1, EV_D = 2, EV_W = 3;

  logic clk = 1'b0, rst_n = 1'b0, run_r = 1'b0;
  logic imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, alu_en, reg_we, halted, fault;
  logic [PC_W-1:0] imem_addr, pc;
  logic [15:0] imem_rdata, ir;
  logic [RW-1:0] retired;

  logic imem_auto = 1'b0, dmem_auto = 1'b0;
  logic iack_a = 1'b0, iack_m = 1'b0, dack_a = 1'b0, dack_m = 1'b0;
  logic [15:0] ird_a = '0, ird_m = '0;

  assign imem_ack   = imem_auto ? iack_a : iack_m;
  assign imem_rdata = imem_auto ? ird_a  : ird_m;
  assign dmem_ack   = dmem_auto ? dack_a : dack_m;

  cpu_sequencer #(.PC_W(PC_W), .TIMEOUT(TMO), .RETIRE_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run_r),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alu_en(alu_en), .reg_we(reg_we), .pc(pc), .retired(retired),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int code; int cyc; int a; int b; } ev_t;
  typedef struct { logic [15:0] insn; int k; int d; } prog_t;

  ev_t   expq[$];
  prog_t progq[$];
  int    dq[$];
  int    ntests = 0, nfail = 0;
  bit    mon_en = 0, first_fetch = 0;
  int    exp_start = 0, exp_pc = 0, exp_ret = 0, n_gen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bump_ret();
    if (exp_ret < (1 << RW) - 1) exp_ret++;
  endtask

  // Instruction-level timing: ALU 4 cycles, load 5+d, store 4+d, NOP 2 (d = extra mem wait)
  task automatic model_fetch(input prog_t p);
    int te;
    logic [2:0] op;
    te = exp_start + p.k;
    op = p.insn[15:13];
    expq.push_back('{EV_F, te, exp_pc, exp_ret});
    exp_pc = (exp_pc + 1) % (1 << PC_W);
    if (op <= 3'd4) begin
      expq.push_back('{EV_A, te + 2, int'(p.insn), 0});
      expq.push_back('{EV_W, te + 3, exp_ret, 0});
      bump_ret();
      exp_start = te + 4;
    end
    else if (op == 3'd5) begin
      dq.push_back(p.d);
      expq.push_back('{EV_A, te + 2, int'(p.insn), 0});
      expq.push_back('{EV_D, te + 3 + p.d, int'(p.insn[0]), 0});
      if (!p.insn[0]) begin
        expq.push_back('{EV_W, te + 4 + p.d, exp_ret, 0});
        exp_start = te + 5 + p.d;
      end
      else exp_start = te + 4 + p.d;
      bump_ret();
    end
    else if (op == 3'd6) begin
      bump_ret();
      exp_start = te + 2;
    end
  endtask

  initial begin : imem_resp
    bit    busy_f = 0;
    int    wc = 0;
    prog_t p;
    forever begin
      @(posedge clk); #1;
      iack_a = 1'b0;
      if (!rst_n) begin busy_f = 0; continue; end
      if (imem_auto && imem_req) begin
        if (!busy_f) begin
          busy_f = 1; wc = 0;
          if (progq.size() > 0) p = progq.pop_front();
          else begin
            p.insn = 16'($urandom);
            p.insn[15:13] = 3'($urandom_range(0, 6));
            p.k = $urandom_range(0, 4);
            p.d = $urandom_range(0, 4);
          end
          if (first_fetch) begin exp_start = cyc; first_fetch = 0; end
        end
        if (wc == p.k) begin
          iack_a = 1'b1; ird_a = p.insn; busy_f = 0; n_gen++;
          model_fetch(p);
        end
        else wc++;
      end
    end
  end

  initial begin : dmem_resp
    bit busy_d = 0;
    int wc = 0, d = 0;
    forever begin
      @(posedge clk); #1;
      dack_a = 1'b0;
      if (!rst_n) begin busy_d = 0; continue; end
      if (dmem_auto && dmem_req) begin
        if (!busy_d) begin busy_d = 1; wc = 0; d = (dq.size() > 0) ? dq.pop_front() : 0; end
        if (wc == d) begin dack_a = 1'b1; busy_d = 0; end
        else wc++;
      end
    end
  end

  task automatic cmp_ev(input int code, input int a, input int b);
    ev_t e;
    if (expq.size() == 0) begin check("unexpected_event", code, 32'hFFFF_FFFF); return; end
    e = expq.pop_front();
    check("ev_code", code, e.code);
    check("ev_cycle", cyc, e.cyc);
    check("ev_data_a", a, e.a);
    check("ev_data_b", b, e.b);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (alu_en || reg_we || dmem_req)
          check("strobe_onehot", int'(alu_en) + int'(reg_we) + int'(dmem_req), 1);
        if (imem_req && imem_ack) cmp_ev(EV_F, int'(imem_addr), int'(retired));
        if (alu_en)               cmp_ev(EV_A, int'(ir), 0);
        if (dmem_req && dmem_ack) cmp_ev(EV_D, int'(dmem_we), 0);
        if (reg_we)               cmp_ev(EV_W, int'(retired), 0);
      end
    end
  end

  task automatic do_reset();
    mon_en = 0; imem_auto = 1'b0; dmem_auto = 1'b0; run_r = 1'b0;
    iack_m = 1'b0; dack_m = 1'b0; first_fetch = 0;
    rst_n = 1'b0;
    expq.delete(); progq.delete(); dq.delete();
    exp_pc = 0; exp_ret = 0; n_gen = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    // reset and idle
    do_reset();
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_retired", retired, 0);
    check("rst_strobes", {imem_req, dmem_req, dmem_we, alu_en, reg_we, halted, fault}, 0);
    n = 0;
    repeat (8) begin @(negedge clk); if (imem_req || pc != 0) n++; end
    check("idle_hold", n, 0);

    // directed ALU/load/store head, then a random stream
    progq.push_back('{16'h0246, 0, 0});
    progq.push_back('{16'hA000, 1, 3});
    progq.push_back('{16'hA001, 0, 2});
    imem_auto = 1'b1; dmem_auto = 1'b1; mon_en = 1; first_fetch = 1;
    @(posedge clk); #1 run_r = 1'b1;
    @(negedge clk);
    check("run_req_wait", imem_req, 0);
    @(negedge clk);
    check("run_req", imem_req, 1);
    check("run_addr", imem_addr, 0);
    for (int i = 0; i < 40000 && n_gen < N_RAND; i++) @(posedge clk);
    #1 run_r = 1'b0;
    check("rand_done", n_gen, N_RAND);
    for (int i = 0; i < 200 && expq.size() > 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n = 0;
    repeat (10) begin @(negedge clk); if (imem_req) n++; end
    check("stop_idle", n, 0);
    check("stop_pc", pc, exp_pc);
    check("stop_retired", retired, exp_ret);
    check("expq_drained", expq.size(), 0);

    // NOP then HALT
    do_reset();
    progq.push_back('{16'hC000, 1, 0});
    progq.push_back('{16'hE000, 0, 0});
    imem_auto = 1'b1; mon_en = 1; first_fetch = 1; run_r = 1'b1;
    for (int i = 0; i < 100 && !halted; i++) @(negedge clk);
    n = 0;
    repeat (20) begin @(negedge clk); if (imem_req || alu_en || reg_we || dmem_req) n++; end
    check("halt_flag", halted, 1);
    check("halt_quiet", n, 0);
    check("halt_pc", pc, 2);
    check("halt_retired", retired, 1);
    check("halt_nofault", fault, 0);
    check("halt_expq", expq.size(), 0);

    // fetch timeout
    do_reset();
    run_r = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req) n++;
      if (fault) break;
    end
    check("tmo_req_cycles", n, TMO);
    check("tmo_fault", fault, 1);
    check("tmo_req_drop", imem_req, 0);
    n = 0;
    repeat (5) begin @(negedge clk); if (imem_req || !fault) n++; end
    check("tmo_sticky", n, 0);
    check("tmo_pc", pc, 0);

    // ack exactly on the timeout cycle wins
    do_reset();
    run_r = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (imem_req) begin
        n++;
        if (n == TMO) begin iack_m = 1'b1; ird_m = 16'hC000; run_r = 1'b0; break; end
      end
    end
    @(posedge clk); #1 iack_m = 1'b0;
    repeat (4) @(negedge clk);
    check("ack15_cycles", n, TMO);
    check("ack15_nofault", fault, 0);
    check("ack15_pc", pc, 1);
    check("ack15_retired", retired, 1);

    // async reset while a load is waiting on data memory
    do_reset();
    progq.push_back('{16'hA000, 0, 20});
    imem_auto = 1'b1; dmem_auto = 1'b1; first_fetch = 1; run_r = 1'b1;
    for (int i = 0; i < 30 && !dmem_req; i++) @(negedge clk);
    check("rst_mem_seen", dmem_req, 1);
    check("rst_mem_pc_before", pc, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mem_req_drop", dmem_req, 0);
    check("rst_mem_pc", pc, 0);
    check("rst_mem_retired", retired, 0);
    imem_auto = 1'b0; dmem_auto = 1'b0; run_r = 1'b0;
    expq.delete(); progq.delete(); dq.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    dack_m = 1'b1; iack_m = 1'b1; ird_m = 16'h0246;
    n = 0;
    repeat (2) begin @(negedge clk); if (imem_req || dmem_req || alu_en || reg_we) n++; end
    @(posedge clk); #1 dack_m = 1'b0; iack_m = 1'b0;
    repeat (3) begin @(negedge clk); if (imem_req || dmem_req || alu_en || reg_we) n++; end
    check("late_ack_quiet", n, 0);
    check("late_ack_pc", pc, 0);
    check("late_ack_ir", ir, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
